branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
Sequencing controller for the branch compare unit in the multi-cycle core. It accepts one resolved-operand branch or jump request from EX and drives the compare datapath (opcode and operands out, 1-bit compare result back). It computes the taken direction and target, checks them against the fetch prediction, and on a mispredict issues a one-cycle flush plus a held redirect to IFU. It also returns the link address to writeback.

Parameters:
XLEN, 32, data/address width.
CNTW, 32, width of performance counters (used only with BRANCH_CTRL_PERF_EN).

Ports:
clk  in  1  core clock
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  branch request valid
req_ready  out  1  controller can accept a request
req_type  in  2  2'b00 BXX, 2'b01 JAL, 2'b10 JALR; 2'b11 is treated as BXX
req_bxx_opcode  in  3  funct3 of conditional branch
req_pc  in  XLEN  PC of branch instruction
req_imm  in  XLEN  sign-extended immediate
req_src1  in  XLEN  rs1 value
req_src2  in  XLEN  rs2 value
req_pred_taken  in  1  fetch predicted taken
beu_opcode  out  3  compare opcode to the compare unit
beu_src1  out  XLEN  compare operand 1
beu_src2  out  XLEN  compare operand 2
beu_result  in  1  compare result, combinational from beu_* outputs
resp_valid  out  1  one-cycle completion pulse to writeback
resp_link  out  XLEN  req_pc+4
flush  out  1  one-cycle flush of younger stages
redirect_valid  out  1  redirect request to IFU
redirect_ready  in  1  IFU accepts redirect
redirect_pc  out  XLEN  corrected fetch PC

Behaviour:
- Reset (async, rst_b=0): state IDLE; all operand registers 0. req_ready=1; resp_valid, flush and redirect_valid 0; beu_*, resp_link and redirect_pc 0. Reset mid-operation aborts any request or redirect in flight with no flush.
- FSM IDLE -> EVAL -> (REDIRECT) -> IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, register all req_* fields and go to EVAL. Only IDLE accepts requests.
- EVAL (1 cycle): beu_opcode/src1/src2 are driven directly from the registered fields in all states.
  - taken = beu_result for BXX; taken = 1 for JAL and JALR.
  - target = pc+imm for BXX/JAL; target = (src1+imm) & ~1 for JALR.
  - All adds are modulo 2^XLEN, so wrap-around is silent.
  - next_pc = taken ? target : pc+4.
  - mispredict = (taken != pred_taken) | JALR. JALR always redirects because the predictor holds direction only.
  - resp_valid=1 this cycle with resp_link=pc+4 for every type.
  - If mispredict: register redirect_pc=next_pc, assert flush (registered, high exactly the first REDIRECT cycle), go to REDIRECT. Else go to IDLE.
- REDIRECT: redirect_valid=1. redirect_pc stays stable until redirect_ready. On redirect_valid&redirect_ready go to IDLE the next cycle. If redirect_ready is already high on the first REDIRECT cycle, flush and the handshake happen in the same cycle.
- Latency (accept at cycle N):
  - resp_valid at N+1.
  - flush and redirect_valid at N+2.
  - Next accept at N+2 with no mispredict; otherwise the cycle after the redirect handshake.
- Misaligned targets are passed through unchanged; exception detection belongs to IFU.

Optional Feature:
BRANCH_CTRL_PERF_EN.
- Defined: adds outputs perf_branch_cnt and perf_mispred_cnt (CNTW each).
  - perf_branch_cnt increments on each EVAL cycle.
  - perf_mispred_cnt increments on each EVAL cycle with mispredict.
  - Both reset to 0, saturate at all-ones and never wrap.
- Undefined: ports and logic are absent.

Decomposition:
- Shared package branch_pkg:
  - req_type enum (BR_BXX, BR_JAL, BR_JALR).
  - FSM state enum (S_IDLE, S_EVAL, S_REDIRECT).
  - Constant INST_BYTES=4.
- One natural combinational sub-module, branch_target_gen: computes target, pc+4 and next_pc from type, pc, imm, src1 and taken.
- The compare unit stays external and is connected through the beu_* ports.

Test Plan:
- BEQ: src1=src2=5, pred_taken=0, pc=0x100, imm=0x20 -> resp_valid with link 0x104 at N+1; flush at N+2; redirect_pc=0x120 held until redirect_ready.
- BNE: src1=src2=5, pred_taken=0 -> no flush, no redirect; req_ready=1 at N+2.
- BLTU: src1=1, src2=0xFFFFFFFF, pred_taken=1 -> taken, no redirect. Same operands with BLT, pred_taken=1 -> not taken, redirect_pc=pc+4.
- JALR: src1=0x1003, imm=0 -> always redirect to 0x1002. Hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable; flush high only on the first REDIRECT cycle.
- JAL: pc=0xFFFFFFF0, imm=0x20, pred_taken=0 -> redirect_pc=0x10 (wrap); resp_link=0xFFFFFFF4.
- Assert rst_b=0 during REDIRECT -> redirect_valid and flush drop immediately; state IDLE; req_ready=1 after release.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencing controller.
package branch_pkg;

  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    BR_BXX  = 2'b00,
    BR_JAL  = 2'b01,
    BR_JALR = 2'b10
  } br_type_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_EVAL     = 2'b01,
    S_REDIRECT = 2'b10
  } state_t;

  // The unused encoding 2'b11 falls back to a conditional branch.
  function automatic br_type_t decode_type(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_type = BR_JAL;
      2'b10:   decode_type = BR_JALR;
      default: decode_type = BR_BXX;
    endcase
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Bus bundle between branch_ctrl and EX, the compare unit, writeback and IFU.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid
// and its payload stay stable until that edge, and ready may depend on nothing but state.
interface branch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_type;
  logic [2:0]      req_bxx_opcode;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            req_pred_taken;

  logic [2:0]      beu_opcode;
  logic [XLEN-1:0] beu_src1;
  logic [XLEN-1:0] beu_src2;
  logic            beu_result;

  logic            resp_valid;
  logic [XLEN-1:0] resp_link;

  logic            flush;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  // Environment side: EX, compare unit, writeback, IFU.
  modport master (
    output req_valid, req_type, req_bxx_opcode, req_pc, req_imm,
           req_src1, req_src2, req_pred_taken, beu_result, redirect_ready,
    input  req_ready, beu_opcode, beu_src1, beu_src2, resp_valid, resp_link,
           flush, redirect_valid, redirect_pc
  );

  // Controller side.
  modport slave (
    input  req_valid, req_type, req_bxx_opcode, req_pc, req_imm,
           req_src1, req_src2, req_pred_taken, beu_result, redirect_ready,
    output req_ready, beu_opcode, beu_src1, beu_src2, resp_valid, resp_link,
           flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/branch_target_gen.sv
// Combinational target / fall-through / next-PC generation for one branch.
module branch_target_gen
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  br_type_t        br_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] src1,
  input  logic            taken,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] target;

  // All additions wrap modulo 2^XLEN; misaligned targets pass through for IFU to trap.
  always_comb begin
    base     = (br_type == BR_JALR) ? src1 : pc;
    sum      = base + imm;
    target   = (br_type == BR_JALR) ? {sum[XLEN-1:1], 1'b0} : sum;
    pc_plus4 = pc + XLEN'(INST_BYTES);
    next_pc  = taken ? target : pc_plus4;
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch sequencing controller: IDLE -> EVAL -> (REDIRECT) -> IDLE.
// Optional macro BRANCH_CTRL_PERF_EN adds saturating branch / mispredict counters.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  branch_ctrl_if.slave      bus,
`ifdef BRANCH_CTRL_PERF_EN
  output logic [CNTW-1:0]   perf_branch_cnt,
  output logic [CNTW-1:0]   perf_mispred_cnt,
`endif
  output state_t            dbg_state
);

  state_t          state_q, state_d;
  br_type_t        type_q;
  logic [2:0]      opcode_q;
  logic [XLEN-1:0] pc_q, imm_q, src1_q, src2_q;
  logic            pred_q;
  logic            flush_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;

  branch_target_gen #(.XLEN(XLEN)) u_target_gen (
    .br_type  (type_q),
    .pc       (pc_q),
    .imm      (imm_q),
    .src1     (src1_q),
    .taken    (taken),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // JALR always redirects: the predictor only knows direction, never the register target.
  always_comb begin
    taken      = (type_q == BR_BXX) ? bus.beu_result : 1'b1;
    mispredict = (taken != pred_q) || (type_q == BR_JALR);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.req_valid)      state_d = S_EVAL;
      S_EVAL:     state_d = mispredict ? S_REDIRECT : S_IDLE;
      S_REDIRECT: if (bus.redirect_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= S_IDLE;
      type_q        <= BR_BXX;
      opcode_q      <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      pred_q        <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.req_valid) begin
        type_q   <= decode_type(bus.req_type);
        opcode_q <= bus.req_bxx_opcode;
        pc_q     <= bus.req_pc;
        imm_q    <= bus.req_imm;
        src1_q   <= bus.req_src1;
        src2_q   <= bus.req_src2;
        pred_q   <= bus.req_pred_taken;
      end
      // Flush is set only on the EVAL->REDIRECT edge, so it covers the first REDIRECT cycle.
      flush_q <= (state_q == S_EVAL) && mispredict;
      if (state_q == S_EVAL && mispredict)
        redirect_pc_q <= next_pc;
    end
  end

`ifdef BRANCH_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perf_branch_cnt  <= '0;
      perf_mispred_cnt <= '0;
    end else if (state_q == S_EVAL) begin
      if (perf_branch_cnt != '1)
        perf_branch_cnt <= perf_branch_cnt + 1'b1;
      if (mispredict && perf_mispred_cnt != '1)
        perf_mispred_cnt <= perf_mispred_cnt + 1'b1;
    end
  end
`endif

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.beu_opcode     = opcode_q;
  assign bus.beu_src1       = src1_q;
  assign bus.beu_src2       = src2_q;
  assign bus.resp_valid     = (state_q == S_EVAL);
  assign bus.resp_link      = (state_q == S_EVAL) ? pc_plus4 : '0;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = (state_q == S_REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: vector table plus hand sequences for hold and reset.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int XLEN = 32;
  localparam int CNTW = 32;

  logic   clk;
  logic   rst_b;
  state_t dbg_state;

  branch_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_CTRL_PERF_EN
  logic [CNTW-1:0] perf_branch_cnt;
  logic [CNTW-1:0] perf_mispred_cnt;
`endif

  branch_ctrl #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .bus              (bus),
`ifdef BRANCH_CTRL_PERF_EN
    .perf_branch_cnt  (perf_branch_cnt),
    .perf_mispred_cnt (perf_mispred_cnt),
`endif
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external compare unit model ----------------
  always_comb begin
    bus.beu_result = 1'b0;
    case (bus.beu_opcode)
      3'b000: bus.beu_result = (bus.beu_src1 == bus.beu_src2);
      3'b001: bus.beu_result = (bus.beu_src1 != bus.beu_src2);
      3'b100: bus.beu_result = ($signed(bus.beu_src1) <  $signed(bus.beu_src2));
      3'b101: bus.beu_result = ($signed(bus.beu_src1) >= $signed(bus.beu_src2));
      3'b110: bus.beu_result = (bus.beu_src1 <  bus.beu_src2);
      3'b111: bus.beu_result = (bus.beu_src1 >= bus.beu_src2);
      default: bus.beu_result = 1'b0;
    endcase
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mp   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  rtype;
    logic [2:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        pred;
    logic        exp_mis;
    logic [31:0] exp_rpc;
    logic [31:0] exp_link;
    int          hold;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic drive_req(input vec_t v);
    bus.req_valid      = 1'b1;
    bus.req_type       = v.rtype;
    bus.req_bxx_opcode = v.op;
    bus.req_pc         = v.pc;
    bus.req_imm        = v.imm;
    bus.req_src1       = v.s1;
    bus.req_src2       = v.s2;
    bus.req_pred_taken = v.pred;
  endtask

  // Entered and left on a falling edge with the controller idle.
  task automatic run_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    check({t, "_ready_idle"}, 64'(bus.req_ready), 64'd1);
    drive_req(v);
    bus.redirect_ready = (v.hold == 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({t, "_resp_valid"}, 64'(bus.resp_valid), 64'd1);
    check({t, "_resp_link"},  64'(bus.resp_link),  64'(v.exp_link));
    check({t, "_beu_op"},     64'(bus.beu_opcode), 64'(v.op));
    check({t, "_beu_src1"},   64'(bus.beu_src1),   64'(v.s1));
    check({t, "_beu_src2"},   64'(bus.beu_src2),   64'(v.s2));
    check({t, "_eval_busy"},  64'(bus.req_ready),  64'd0);
    check({t, "_eval_flush"}, 64'(bus.flush),      64'd0);
    exp_br++;
    if (v.exp_mis) exp_mp++;
    @(negedge clk);
    check({t, "_flush"},    64'(bus.flush),          64'(v.exp_mis));
    check({t, "_rvalid"},   64'(bus.redirect_valid), 64'(v.exp_mis));
    check({t, "_ready_n2"}, 64'(bus.req_ready),      64'(!v.exp_mis));
    check({t, "_resp_off"}, 64'(bus.resp_valid),     64'd0);
    if (v.exp_mis) begin
      check({t, "_rpc"}, 64'(bus.redirect_pc), 64'(v.exp_rpc));
      for (int k = 1; k <= v.hold; k++) begin
        @(negedge clk);
        check({t, $sformatf("_hold%0d_rvalid", k)}, 64'(bus.redirect_valid), 64'd1);
        check({t, $sformatf("_hold%0d_flush", k)},  64'(bus.flush),          64'd0);
        check({t, $sformatf("_hold%0d_rpc", k)},    64'(bus.redirect_pc),    64'(v.exp_rpc));
        if (k == v.hold) bus.redirect_ready = 1'b1;
      end
      @(negedge clk);
      bus.redirect_ready = 1'b0;
      check({t, "_post_rvalid"}, 64'(bus.redirect_valid), 64'd0);
      check({t, "_post_ready"},  64'(bus.req_ready),      64'd1);
    end
  endtask

  initial begin
    //          type   op      pc            imm           s1            s2            pred mis  rpc           link          hold
    vecs[0] = '{2'b00, 3'b000, 32'h0000_0100, 32'h0000_0020, 32'd5,        32'd5,        1'b0, 1'b1, 32'h0000_0120, 32'h0000_0104, 2};
    vecs[1] = '{2'b00, 3'b001, 32'h0000_0100, 32'h0000_0020, 32'd5,        32'd5,        1'b0, 1'b0, 32'h0,         32'h0000_0104, 0};
    vecs[2] = '{2'b00, 3'b110, 32'h0000_0200, 32'h0000_0040, 32'd1,        32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,        32'h0000_0204, 0};
    vecs[3] = '{2'b00, 3'b100, 32'h0000_0200, 32'h0000_0040, 32'd1,        32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0204, 32'h0000_0204, 0};
    vecs[4] = '{2'b10, 3'b000, 32'h0000_0300, 32'h0000_0000, 32'h0000_1003, 32'h0,        1'b1, 1'b1, 32'h0000_1002, 32'h0000_0304, 3};
    vecs[5] = '{2'b01, 3'b000, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFF4, 1};
    vecs[6] = '{2'b01, 3'b000, 32'h0000_0400, 32'hFFFF_FFF0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,         32'h0000_0404, 0};
    vecs[7] = '{2'b11, 3'b101, 32'h0000_0500, 32'h0000_0008, 32'd7,        32'd3,        1'b0, 1'b1, 32'h0000_0508, 32'h0000_0504, 0};
    vecs[8] = '{2'b00, 3'b111, 32'h0000_0600, 32'h0000_0010, 32'd3,        32'd7,        1'b1, 1'b1, 32'h0000_0604, 32'h0000_0604, 1};
    vecs[9] = '{2'b10, 3'b000, 32'h0000_0700, 32'hFFFF_FFFF, 32'h0000_2000, 32'h0,        1'b0, 1'b1, 32'h0000_1FFE, 32'h0000_0704, 0};

    rst_b              = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_type       = 2'b00;
    bus.req_bxx_opcode = 3'b000;
    bus.req_pc         = '0;
    bus.req_imm        = '0;
    bus.req_src1       = '0;
    bus.req_src2       = '0;
    bus.req_pred_taken = 1'b0;
    bus.redirect_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready",     64'(bus.req_ready),      64'd1);
    check("rst_resp",      64'(bus.resp_valid),     64'd0);
    check("rst_flush",     64'(bus.flush),          64'd0);
    check("rst_rvalid",    64'(bus.redirect_valid), 64'd0);
    check("rst_beu_op",    64'(bus.beu_opcode),     64'd0);
    check("rst_beu_src1",  64'(bus.beu_src1),       64'd0);
    check("rst_beu_src2",  64'(bus.beu_src2),       64'd0);
    check("rst_link",      64'(bus.resp_link),      64'd0);
    check("rst_rpc",       64'(bus.redirect_pc),    64'd0);
    check("rst_state",     64'(dbg_state),          64'(S_IDLE));
    rst_b = 1'b1;

    for (int i = 0; i < NV; i++)
      run_vec(i, vecs[i]);

    // Reset while a redirect waits for IFU: everything drops at once, no flush.
    drive_req(vecs[4]);
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("ar_pre_rvalid", 64'(bus.redirect_valid), 64'd1);
    check("ar_pre_flush",  64'(bus.flush),          64'd1);
    rst_b = 1'b0;
    #1;
    check("ar_rvalid", 64'(bus.redirect_valid), 64'd0);
    check("ar_flush",  64'(bus.flush),          64'd0);
    check("ar_state",  64'(dbg_state),          64'(S_IDLE));
    check("ar_rpc",    64'(bus.redirect_pc),    64'd0);
    exp_br = 0;
    exp_mp = 0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("ar_ready", 64'(bus.req_ready),      64'd1);
    check("ar_idle",  64'(bus.redirect_valid), 64'd0);

    // Life continues normally after the abort.
    run_vec(100, vecs[0]);
    run_vec(101, vecs[2]);

`ifdef BRANCH_CTRL_PERF_EN
    check("perf_branch",  64'(perf_branch_cnt),  64'(exp_br));
    check("perf_mispred", 64'(perf_mispred_cnt), 64'(exp_mp));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
